// File: rtl/ipu_int_gen_pkg.sv
// ----------------------------------------------------------------------------
// ipu_pkg
// Shared constants, FSM state encoding and helpers for the grid-button
// interrupt generator (ipu_int_gen) and its debounce sub-module.
// ----------------------------------------------------------------------------
package ipu_pkg;

  localparam int NUM_CELLS   = 9;
  localparam int COORD_W     = 4;
  localparam int QUEUE_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } ipu_state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [COORD_W-1:0] lowest_index(input logic [NUM_CELLS-1:0] ev);
    logic [COORD_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (ev[i]) idx = COORD_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ipu_int_gen_if.sv
// ----------------------------------------------------------------------------
// ipu_int_gen_if
// Interrupt handshake between the grid interrupt generator and the processor.
//   int_ack    : acknowledge from the processor fetch stage (level or pulse)
//   ipu_int    : interrupt request
//   grid_coord : index 0..8 of the pressed cell
//   drop       : one-cycle pulse when a press event is discarded
// Modports: master = interrupt generator, slave = processor side.
// ----------------------------------------------------------------------------
interface ipu_int_gen_if;
  import ipu_pkg::*;

  logic               int_ack;
  logic               ipu_int;
  logic [COORD_W-1:0] grid_coord;
  logic               drop;

  modport master (
    input  int_ack,
    output ipu_int,
    output grid_coord,
    output drop
  );

  modport slave (
    output int_ack,
    input  ipu_int,
    input  grid_coord,
    input  drop
  );

endinterface

// File: rtl/ipu_int_gen_debounce.sv
// ----------------------------------------------------------------------------
// ipu_debounce
// One button bit: 2-flop synchronizer followed by a counter debouncer.
// The stable level only follows the synchronized level once the two have
// differed for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts
// the count.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   din      : raw asynchronous button level
//   stable   : debounced level
//   rise     : high on the first cycle stable reads 1 after a 0->1 change
// ----------------------------------------------------------------------------
module ipu_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // The count reaching CNT_MAX on a mismatching cycle is the Nth consecutive
  // mismatch, so the level is accepted on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      stable  <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      if (sync_q2 != stable) begin
        if (cnt == CNT_MAX) begin
          stable <= sync_q2;
          rise   <= sync_q2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ipu_int_gen.sv
// ----------------------------------------------------------------------------
// ipu_int_gen
// Turns debounced presses on a 3x3 button grid into processor interrupts.
// A press loads grid_coord and raises ipu_int until the processor acks; the
// FSM then waits for ack to drop so a level ack is consumed only once.
// Simultaneous presses resolve to the lowest index; losers pulse drop.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   btn[8:0] : raw pushbuttons, bit i = cell i (row-major)
//   irq      : ipu_int_gen_if.master handshake (int_ack/ipu_int/grid_coord/drop)
// Optional: define IPU_QUEUE_EN to add a 4-entry FIFO that buffers presses
// arriving while a request is outstanding. Without it those presses are
// dropped.
// ----------------------------------------------------------------------------
module ipu_int_gen
  import ipu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CELLS-1:0] btn,
  ipu_int_gen_if.master        irq
);

  ipu_state_t state, state_nxt;

  logic [NUM_CELLS-1:0] stable_lvl;
  logic [NUM_CELLS-1:0] rise_lvl;
  logic [NUM_CELLS-1:0] ev;
  logic                 any_ev;
  logic                 multi_ev;
  logic [COORD_W-1:0]   winner;

  logic                 load;
  logic [COORD_W-1:0]   load_val;
  logic                 discard;
  logic [COORD_W-1:0]   coord_q;
  logic                 drop_q;
  logic                 ipu_int_c;

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    ipu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .din   (btn[i]),
      .stable(stable_lvl[i]),
      .rise  (rise_lvl[i])
    );
  end

  // A press is the rise qualified by the debounced level being high.
  always_comb begin
    ev       = rise_lvl & stable_lvl;
    any_ev   = |ev;
    multi_ev = |(ev & (ev - NUM_CELLS'(1)));
    winner   = lowest_index(ev);
  end

`ifdef IPU_QUEUE_EN
  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  logic [COORD_W-1:0] q_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   q_wr;
  logic [PTR_W-1:0]   q_rd;
  logic [PTR_W:0]     q_count;
  logic               q_empty;
  logic               q_full;
  logic               pop;
  logic               push_req;
  logic               push;

  // In IDLE the queue head wins over a fresh press, which is queued behind
  // it. A full queue still accepts a push when the same cycle pops.
  always_comb begin
    q_empty  = (q_count == '0);
    q_full   = (q_count == (PTR_W + 1)'(QUEUE_DEPTH));
    pop      = (state == IDLE) && !q_empty;
    push_req = any_ev && ((state != IDLE) || !q_empty);
    push     = push_req && (!q_full || pop);
    load     = (state == IDLE) && (any_ev || !q_empty);
    load_val = q_empty ? winner : q_mem[q_rd];
    discard  = multi_ev || (push_req && !push);
  end

  // FIFO storage and pointers; only the occupancy needs clearing on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr    <= '0;
      q_rd    <= '0;
      q_count <= '0;
    end else begin
      if (push) begin
        q_mem[q_wr] <= winner;
        q_wr        <= q_wr + PTR_W'(1);
      end
      if (pop) q_rd <= q_rd + PTR_W'(1);
      if (push && !pop)      q_count <= q_count + (PTR_W + 1)'(1);
      else if (pop && !push) q_count <= q_count - (PTR_W + 1)'(1);
    end
  end
`else
  // Only an idle FSM can take a press; anything else is discarded.
  always_comb begin
    load     = (state == IDLE) && any_ev;
    load_val = winner;
    discard  = multi_ev || (any_ev && (state != IDLE));
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: RELEASE waits for ack to fall so a held ack counts once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load)         state_nxt = REQ;
      REQ:     if (irq.int_ack)  state_nxt = RELEASE;
      RELEASE: if (!irq.int_ack) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    ipu_int_c = (state == REQ);
  end

  // Coordinate loads only when a request is launched, so it holds through
  // REQ and keeps its last value afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      coord_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (load) coord_q <= load_val;
      drop_q <= discard;
    end
  end

  assign irq.ipu_int    = ipu_int_c;
  assign irq.grid_coord = coord_q;
  assign irq.drop       = drop_q;

endmodule

// File: tb/tb_ipu_int_gen.sv
// ----------------------------------------------------------------------------
// tb_ipu_int_gen
// Directed bench for ipu_int_gen with DEBOUNCE_CYCLES=4. A button set just
// after an edge is debounced six edges later and raises ipu_int on the
// seventh. Expectations follow IPU_QUEUE_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_ipu_int_gen;
  import ipu_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [NUM_CELLS-1:0] btn;

  int vectors     = 0;
  int miscompares = 0;
  int drop_cnt    = 0;
  int req_cnt     = 0;
  logic prev_int  = 1'b0;

  ipu_int_gen_if bus ();

  ipu_int_gen #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .irq(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count drop pulse cycles and rising edges of ipu_int between edges.
  always @(negedge clk) begin
    if (bus.drop === 1'b1) drop_cnt++;
    if (bus.ipu_int === 1'b1 && prev_int === 1'b0) req_cnt++;
    prev_int = bus.ipu_int;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CELLS-1:0] b, input logic ack, input int cycles);
    btn         = b;
    bus.int_ack = ack;
    tick(cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int d0;
    int r0;
    int exp_q [4];
    exp_q = '{3, 5, 6, 8};
    btn         = '0;
    bus.int_ack = 1'b0;
    rst         = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    checkOutput("reset_int",   32'(bus.ipu_int),    0);
    checkOutput("reset_coord", 32'(bus.grid_coord), 0);
    checkOutput("reset_drop",  32'(bus.drop),       0);

    $display("[TB] single press on cell 4");
    applyStimulus(9'h010, 1'b0, 6);
    checkOutput("c4_before_req", 32'(bus.ipu_int), 0);
    tick(1);
    checkOutput("c4_req",   32'(bus.ipu_int),    1);
    checkOutput("c4_coord", 32'(bus.grid_coord), 4);
    applyStimulus(9'h010, 1'b0, 3);
    applyStimulus(9'h000, 1'b0, 8);
    checkOutput("c4_held_int",   32'(bus.ipu_int),    1);
    checkOutput("c4_held_coord", 32'(bus.grid_coord), 4);
    applyStimulus(9'h000, 1'b1, 1);
    checkOutput("c4_ack_int",   32'(bus.ipu_int),    0);
    checkOutput("c4_ack_coord", 32'(bus.grid_coord), 4);
    applyStimulus(9'h000, 1'b0, 2);
    checkOutput("c4_idle_int", 32'(bus.ipu_int), 0);
    checkOutput("c4_req_count", 32'(req_cnt),  1);
    checkOutput("c4_drop_count", 32'(drop_cnt), 0);

    $display("[TB] 3-cycle glitch on cell 2");
    d0 = drop_cnt;
    r0 = req_cnt;
    applyStimulus(9'h004, 1'b0, 3);
    applyStimulus(9'h000, 1'b0, 12);
    checkOutput("glitch_int",  32'(bus.ipu_int), 0);
    checkOutput("glitch_reqs", 32'(req_cnt),  32'(r0));
    checkOutput("glitch_drop", 32'(drop_cnt), 32'(d0));

    $display("[TB] cells 7 and 1 together");
    d0 = drop_cnt;
    applyStimulus(9'h082, 1'b0, 7);
    checkOutput("pair_int",   32'(bus.ipu_int),    1);
    checkOutput("pair_coord", 32'(bus.grid_coord), 1);
    checkOutput("pair_drop",  32'(bus.drop),       1);
    tick(1);
    checkOutput("pair_drop_end", 32'(bus.drop),    0);
    checkOutput("pair_drop_cnt", 32'(drop_cnt - d0), 1);

    $display("[TB] held ack for 5 cycles");
    r0 = req_cnt;
    applyStimulus(9'h000, 1'b1, 1);
    checkOutput("hold_ack_fall", 32'(bus.ipu_int), 0);
    applyStimulus(9'h000, 1'b1, 4);
    checkOutput("hold_ack_low",  32'(bus.ipu_int), 0);
    checkOutput("hold_ack_reqs", 32'(req_cnt), 32'(r0));
    applyStimulus(9'h000, 1'b0, 9);
    checkOutput("hold_idle_int",   32'(bus.ipu_int),    0);
    checkOutput("hold_idle_coord", 32'(bus.grid_coord), 1);

    $display("[TB] presses 3,5,6,8,0 during a pending request");
    applyStimulus(9'h010, 1'b0, 7);
    checkOutput("burst_req_coord", 32'(bus.grid_coord), 4);
    d0 = drop_cnt;
    applyStimulus(9'h018, 1'b0, 1);
    applyStimulus(9'h038, 1'b0, 1);
    applyStimulus(9'h078, 1'b0, 1);
    applyStimulus(9'h178, 1'b0, 1);
    applyStimulus(9'h179, 1'b0, 10);
    applyStimulus(9'h000, 1'b0, 10);
`ifdef IPU_QUEUE_EN
    checkOutput("burst_drops", 32'(drop_cnt - d0), 1);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(9'h000, 1'b1, 1);
      applyStimulus(9'h000, 1'b0, 2);
      checkOutput("queue_int",   32'(bus.ipu_int),    1);
      checkOutput("queue_coord", 32'(bus.grid_coord), 32'(exp_q[j]));
    end
    applyStimulus(9'h000, 1'b1, 1);
    applyStimulus(9'h000, 1'b0, 4);
    checkOutput("queue_drained", 32'(bus.ipu_int), 0);
`else
    checkOutput("burst_drops", 32'(drop_cnt - d0), 5);
    applyStimulus(9'h000, 1'b1, 1);
    applyStimulus(9'h000, 1'b0, 4);
    checkOutput("burst_after_int",   32'(bus.ipu_int),    0);
    checkOutput("burst_after_coord", 32'(bus.grid_coord), 4);
`endif

    $display("[TB] reset during REQ");
    applyStimulus(9'h040, 1'b0, 7);
    checkOutput("rst_pre_int",   32'(bus.ipu_int),    1);
    checkOutput("rst_pre_coord", 32'(bus.grid_coord), 6);
    btn = '0;
    rst = 1'b1;
    tick(1);
    checkOutput("rst_int",   32'(bus.ipu_int),    0);
    checkOutput("rst_coord", 32'(bus.grid_coord), 0);
    rst = 1'b0;
    tick(8);
    checkOutput("rst_idle_int", 32'(bus.ipu_int), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
